mem_responder: RTL and testbench

Memory-side responder for the core's control unit. It accepts the single outstanding instruction-fetch or load/store request issued during the FETCH/EXECUTE phases and performs the access on a synchronous single-port word SRAM with configurable wait states. It steers byte lanes, zero- or sign-extends sub-word loads, and returns one response pulse per request. It detects misaligned and out-of-range accesses and reports them as faults without touching memory.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared request encodings and responder state for the memory path
package mem_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, byte enables and load extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata[{offset, 3'b000} +: 8];
    half_sel    = offset[1] ? rdata[31:16] : rdata[15:0];
    be          = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = 32'd0;
    case (size)
      SZ_BYTE: begin
        be          = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be          = 4'b0011 << offset;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be          = 4'b1111;
        rdata_ext   = rdata;
      end
      default: begin
        be          = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding fetch/load/store responder on a wait-stated word SRAM
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fetch,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // One extra bit so WAIT_STATES=7 can load a count of 8
  localparam int CNT_W = WAIT_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  size_t              size_q;
  logic               signed_q, write_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q, rdata_q;
  logic               fault_q;
  size_t              eff_size;
  logic               eff_signed, bad, accept, done;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata, lane_rdata;

  always_comb begin
    eff_size   = req_fetch ? SZ_HALF : size_t'(req_size);
    eff_signed = req_signed & ~req_fetch;
    bad        = (eff_size == SZ_RSVD)
               | ((eff_size == SZ_HALF) && req_addr[0])
               | ((eff_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
               | ((req_addr >> (ADDR_W + 2)) != 32'd0)
               | (req_fetch & req_write);
  end

  assign accept = req_valid && (state == ST_IDLE);
  assign done   = (state == ST_ACCESS) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Response registers only change on the edge entering RESP, so they hold between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else if (accept) begin
      size_q   <= eff_size;
      signed_q <= eff_signed;
      write_q  <= req_write;
      addr_q   <= req_addr[ADDR_W+1:0];
      wdata_q  <= req_wdata;
      cnt      <= CNT_INIT;
      if (bad) begin
        rdata_q <= 32'd0;
        fault_q <= 1'b1;
      end
    end else if (done) begin
      rdata_q <= write_q ? 32'd0 : lane_rdata;
      fault_q <= 1'b0;
    end else if (state == ST_ACCESS) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_en    = (state == ST_ACCESS) && (cnt == CNT_INIT);
    mem_we    = (mem_en && write_q) ? lane_be : 4'b0000;
    mem_addr  = addr_q[ADDR_W+1:2];
    mem_wdata = lane_wdata;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  mem_lane_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .sign_ext    (signed_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (lane_be),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboarded bench for mem_responder at WAIT_STATES 1, 0, 3 and 7
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int N      = 4;
  localparam int ADDR_W = 12;

  typedef struct {
    logic        wr;
    logic        fe;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  we;
  } vec_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic              req_valid_a [N];
  logic              req_ready_a [N];
  logic              req_fetch_a [N];
  logic              req_write_a [N];
  logic [1:0]        req_size_a  [N];
  logic              req_signed_a[N];
  logic [31:0]       req_addr_a  [N];
  logic [31:0]       req_wdata_a [N];
  logic              rsp_valid_a [N];
  logic [31:0]       rsp_rdata_a [N];
  logic              rsp_fault_a [N];
  logic              mem_en_a    [N];
  logic [3:0]        mem_we_a    [N];
  logic [ADDR_W-1:0] mem_addr_a  [N];
  logic [31:0]       mem_wdata_a [N];
  logic [31:0]       mem_rdata_a [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
    logic [31:0] mem [0:4095];
    logic [31:0] pd  [0:WS];
    logic        pv  [0:WS];

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_a[g]),
      .req_fetch  (req_fetch_a[g]),
      .req_write  (req_write_a[g]),
      .req_size   (req_size_a[g]),
      .req_signed (req_signed_a[g]),
      .req_addr   (req_addr_a[g]),
      .req_wdata  (req_wdata_a[g]),
      .rsp_valid  (rsp_valid_a[g]),
      .rsp_rdata  (rsp_rdata_a[g]),
      .rsp_fault  (rsp_fault_a[g]),
      .mem_en     (mem_en_a[g]),
      .mem_we     (mem_we_a[g]),
      .mem_addr   (mem_addr_a[g]),
      .mem_wdata  (mem_wdata_a[g]),
      .mem_rdata  (mem_rdata_a[g])
    );

    // SRAM model: read data is only meaningful exactly 1+WS cycles after the enable cycle
    always @(posedge clk) begin
      if (mem_en_a[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_we_a[g][b]) mem[mem_addr_a[g]][8*b +: 8] <= mem_wdata_a[g][8*b +: 8];
      end
      pv[0] <= mem_en_a[g] && (mem_we_a[g] == 4'b0000);
      pd[0] <= mem[mem_addr_a[g]];
      for (int k = 1; k <= WS; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end

    assign mem_rdata_a[g] = pv[WS] ? pd[WS] : 32'h0BAD_F00D;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rsp_valid_a[i]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_rsp_inst%0d", i), 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_inst", i, mon_e.inst);
          check("rsp_cycle", cyc, mon_e.cyc);
          check("rsp_rdata", rsp_rdata_a[i], mon_e.rdata);
          check("rsp_fault", {31'd0, rsp_fault_a[i]}, {31'd0, mon_e.fault});
        end
      end
    end
  end

  task automatic drive(input int i, input vec_t v);
    req_fetch_a[i]  = v.fe;
    req_write_a[i]  = v.wr;
    req_size_a[i]   = v.sz;
    req_signed_a[i] = v.sg;
    req_addr_a[i]   = v.addr;
    req_wdata_a[i]  = v.wdata;
  endtask

  task automatic wait_ready(input int i, output bit ok);
    int n = 0;
    while (!req_ready_a[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready_a[i];
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input int i, input vec_t v);
    int acc;
    bit ok;
    @(negedge clk);
    drive(i, v);
    req_valid_a[i] = 1'b1;
    wait_ready(i, ok);
    if (!ok) begin
      req_valid_a[i] = 1'b0;
      return;
    end
    acc = cyc + 1;
    sb.push_back('{i, acc + (v.fault ? 0 : ws_of(i) + 2), v.rdata, v.fault});
    @(negedge clk);
    req_valid_a[i] = 1'b0;
    check("c1_ready", {31'd0, req_ready_a[i]}, 32'd0);
    check("c1_mem_en", {31'd0, mem_en_a[i]}, {31'd0, !v.fault});
    check("c1_mem_we", {28'd0, mem_we_a[i]}, {28'd0, v.we});
    if (!v.fault) check("c1_mem_addr", {20'd0, mem_addr_a[i]}, {20'd0, v.addr[13:2]});
    @(negedge clk);
    check("c2_mem_en", {31'd0, mem_en_a[i]}, 32'd0);
    check("c2_mem_we", {28'd0, mem_we_a[i]}, 32'd0);
    wait_ready(i, ok);
    if (ok) check("ready_cycle", cyc - acc + 1, v.fault ? 2 : ws_of(i) + 4);
    check("sb_drained", sb.size(), 0);
  endtask

  vec_t vt[$];
  vec_t va, vb;
  int   acc_a;
  bit   ok;

  initial begin
    for (int i = 0; i < N; i++) begin
      req_valid_a[i]  = 1'b0;
      req_fetch_a[i]  = 1'b0;
      req_write_a[i]  = 1'b0;
      req_size_a[i]   = 2'b00;
      req_signed_a[i] = 1'b0;
      req_addr_a[i]   = 32'd0;
      req_wdata_a[i]  = 32'd0;
    end

    //          wr  fe  sz     sg  addr          wdata         rdata         flt we
    vt.push_back('{1, 0, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 4'b1111});
    vt.push_back('{0, 0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 4'b0000});
    vt.push_back('{1, 0, 2'b00, 0, 32'h13,   32'h00000080, 32'h0,        0, 4'b1000});
    vt.push_back('{0, 0, 2'b00, 1, 32'h13,   32'h0,        32'hFFFFFF80, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b00, 0, 32'h13,   32'h0,        32'h00000080, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0, 4'b0000});
    vt.push_back('{1, 0, 2'b10, 0, 32'h14,   32'h11223344, 32'h0,        0, 4'b1111});
    vt.push_back('{1, 0, 2'b01, 0, 32'h16,   32'h5555ABCD, 32'h0,        0, 4'b1100});
    vt.push_back('{0, 0, 2'b10, 0, 32'h14,   32'h0,        32'hABCD3344, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b01, 1, 32'h16,   32'h0,        32'hFFFFABCD, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b01, 0, 32'h14,   32'h0,        32'h00003344, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b00, 1, 32'h15,   32'h0,        32'h00000033, 0, 4'b0000});
    vt.push_back('{0, 1, 2'b10, 1, 32'h16,   32'h0,        32'h0000ABCD, 0, 4'b0000});
    vt.push_back('{0, 0, 2'b01, 0, 32'h11,   32'h0,        32'h0,        1, 4'b0000});
    vt.push_back('{1, 1, 2'b01, 0, 32'h10,   32'hFFFFFFFF, 32'h0,        1, 4'b0000});
    vt.push_back('{0, 0, 2'b10, 0, 32'h4000, 32'h0,        32'h0,        1, 4'b0000});
    vt.push_back('{0, 0, 2'b10, 0, 32'h12,   32'h0,        32'h0,        1, 4'b0000});
    vt.push_back('{0, 0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1, 4'b0000});
    vt.push_back('{0, 1, 2'b00, 0, 32'h13,   32'h0,        32'h0,        1, 4'b0000});
    vt.push_back('{1, 0, 2'b10, 0, 32'h4010, 32'hFFFFFFFF, 32'h0,        1, 4'b0000});
    vt.push_back('{0, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0, 4'b0000});
    vt.push_back('{1, 0, 2'b00, 0, 32'h3FFF, 32'h0000007F, 32'h0,        0, 4'b1000});
    vt.push_back('{0, 0, 2'b00, 1, 32'h3FFF, 32'h0,        32'h0000007F, 0, 4'b0000});

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready_a[0]}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_a[0]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata_a[0], 32'd0);
    check("rst_rsp_fault", {31'd0, rsp_fault_a[0]}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en_a[0]}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we_a[0]}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr_a[0]}, 32'd0);
    check("rst_mem_wdata", mem_wdata_a[0], 32'd0);
    rst = 1'b1;

    foreach (vt[k]) do_req(0, vt[k]);

    // Held request during a busy access: second accept only in cycle WS+4
    va = '{0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 4'b0000};
    vb = '{0, 0, 2'b10, 0, 32'h14, 32'h0, 32'hABCD3344, 0, 4'b0000};
    @(negedge clk);
    drive(0, va);
    req_valid_a[0] = 1'b1;
    wait_ready(0, ok);
    acc_a = cyc + 1;
    sb.push_back('{0, acc_a + ws_of(0) + 2, va.rdata, 1'b0});
    @(negedge clk);
    drive(0, vb);
    @(negedge clk);
    wait_ready(0, ok);
    check("busy_accept_cycle", cyc - acc_a + 1, ws_of(0) + 4);
    sb.push_back('{0, cyc + 1 + ws_of(0) + 2, vb.rdata, 1'b0});
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    @(negedge clk);
    wait_ready(0, ok);
    check("busy_sb_drained", sb.size(), 0);

    // Reset in cycle 2 of a load: access abandoned, no response
    @(negedge clk);
    drive(0, va);
    req_valid_a[0] = 1'b1;
    wait_ready(0, ok);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready_a[0]}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid_a[0]}, 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata_a[0], 32'd0);
    check("mid_rst_rsp_fault", {31'd0, rsp_fault_a[0]}, 32'd0);
    check("mid_rst_mem_en", {31'd0, mem_en_a[0]}, 32'd0);
    check("mid_rst_mem_we", {28'd0, mem_we_a[0]}, 32'd0);
    check("mid_rst_mem_addr", {20'd0, mem_addr_a[0]}, 32'd0);
    check("mid_rst_mem_wdata", mem_wdata_a[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready_a[0]}, 32'd1);
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp", sb.size(), 0);

    // Wait-state sweep: fetch @0x02 returns the upper halfword, zero-extended
    for (int i = 1; i < N; i++) begin
      do_req(i, '{1, 0, 2'b10, 0, 32'h0, 32'hCAFE8001, 32'h0,        0, 4'b1111});
      do_req(i, '{0, 1, 2'b00, 1, 32'h2, 32'h0,        32'h0000CAFE, 0, 4'b0000});
      do_req(i, '{0, 0, 2'b01, 1, 32'h0, 32'h0,        32'h00008001 | 32'hFFFF0000, 0, 4'b0000});
    end

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
